corescore_emitter_uart: RTL and testbench

CORESCORE_EMITTER_UART -- requirements
Module: corescore_emitter_uart

---
 rtl/corescore_emitter_uart.sv | 129 ++++++++++++
 tb/tb_corescore_emitter_uart.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/corescore_emitter_uart.sv
// corescore_emitter_uart: 8N1 UART transmitter.
// Accepts a byte on i_valid && o_ready. It sends a start bit, eight data bits
// LSB first and a stop bit, each held for DIV = clk_freq_hz / baud_rate cycles.
// If i_valid is high on the edge that ends the stop bit, the next frame is
// chained onto that edge, so back-to-back frames leave no idle gap on the line.
module corescore_emitter_uart #(
   parameter int clk_freq_hz = 50000000,
   parameter int baud_rate   = 115200
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_uart_tx
);

   localparam int DIV = clk_freq_hz / baud_rate;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [3:0]    BIT_DATA_LAST = 4'd8;
   localparam logic [3:0]    BIT_STOP      = 4'd9;

   // A bit period below two cycles cannot be counted; stop elaboration.
   if (DIV < 2) begin : g_div_check
      $error("corescore_emitter_uart: clk_freq_hz/baud_rate must be >= 2");
   end

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [3:0]      bit_q, bit_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic            tx_q, tx_d;
   logic            ready_q, ready_d;

   logic            bit_end_s;

   assign bit_end_s = (baud_q == BAUD_LAST);
   assign o_ready   = ready_q;
   assign o_uart_tx = tx_q;

   // Next-state logic: accept, count bit periods, shift out data, chain frames.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      baud_d  = baud_q;
      tx_d    = tx_q;
      ready_d = ready_q;

      case (state_q)
         ST_IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            bit_d   = 4'd0;
            baud_d  = '0;
            if (i_valid) begin
               state_d = ST_SHIFT;
               shreg_d = i_data;
               tx_d    = 1'b0;
               ready_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bit_end_s) begin
               baud_d = '0;
               if (bit_q == BIT_STOP) begin
                  // Stop bit complete: either chain the next frame or go idle.
                  bit_d = 4'd0;
                  if (i_valid) begin
                     state_d = ST_SHIFT;
                     shreg_d = i_data;
                     tx_d    = 1'b0;
                     ready_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                     ready_d = 1'b1;
                  end
               end else if (bit_q == BIT_DATA_LAST) begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end else begin
               baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
            shreg_d = 8'h00;
            bit_d   = 4'd0;
            baud_d  = '0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset forces an idle-high line at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= 8'h00;
         bit_q   <= 4'd0;
         baud_q  <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         baud_q  <= baud_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// tb_corescore_emitter_uart: directed checks of the UART transmitter.
// Instance A uses the default clock and baud parameters (DIV = 434).
// Instance B uses 1000 Hz / 100 baud (DIV = 10).
module tb_corescore_emitter_uart;

   logic       clk = 1'b0;
   logic       rst_a_n, rst_b_n;
   logic       valid_a, valid_b;
   logic [7:0] data_a, data_b;
   logic       ready_a, ready_b, tx_a, tx_b;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   corescore_emitter_uart u_dut_a (
      .i_clk     (clk),
      .i_rst_n   (rst_a_n),
      .i_data    (data_a),
      .i_valid   (valid_a),
      .o_ready   (ready_a),
      .o_uart_tx (tx_a)
   );

   corescore_emitter_uart #(
      .clk_freq_hz (1000),
      .baud_rate   (100)
   ) u_dut_b (
      .i_clk     (clk),
      .i_rst_n   (rst_b_n),
      .i_data    (data_b),
      .i_valid   (valid_b),
      .o_ready   (ready_b),
      .o_uart_tx (tx_b)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic tx_of(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic ready_of(input bit sel);
      return sel ? ready_b : ready_a;
   endfunction

   task automatic drive(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         valid_b = v;
         data_b  = d;
      end else begin
         valid_a = v;
         data_a  = d;
      end
   endtask

   // Request a byte; this returns 1 time unit after the accepting edge T.
   task automatic start(input bit sel, input logic [7:0] d);
      @(negedge clk);
      drive(sel, 1'b1, d);
      @(posedge clk);
      #1;
   endtask

   // Observe one frame from T for 10*div cycles and count matching cycles per bit.
   // At cycle 0 i_data changes to nd, and i_valid drops unless hold is set.
   // If inj >= 0, a one-cycle 0xFF request is pulsed at cycle inj.
   task automatic watch(input bit sel, input string tag, input logic [7:0] d,
                        input int div, input int inj, input bit hold,
                        input logic [7:0] nd);
      int   cnt[10];
      int   rdy_low;
      int   b;
      logic expb;
      for (int i = 0; i < 10; i++) cnt[i] = 0;
      rdy_low = 0;
      for (int j = 0; j < 10 * div; j++) begin
         b = j / div;
         if (j == 0) drive(sel, hold, nd);
         if (inj >= 0 && j == inj) drive(sel, 1'b1, 8'hFF);
         if (inj >= 0 && j == inj + 1) drive(sel, 1'b0, 8'hFF);
         if (b == 0)      expb = 1'b0;
         else if (b == 9) expb = 1'b1;
         else             expb = d[b-1];
         if (tx_of(sel) == expb) cnt[b]++;
         if (!ready_of(sel)) rdy_low++;
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 10; i++) check_val($sformatf("%s_bit%0d", tag, i), cnt[i], div);
      check_val({tag, "_busy"}, rdy_low, 10 * div);
   endtask

   task automatic check_idle(input bit sel, input string tag);
      check_val({tag, "_ready"}, int'(ready_of(sel)), 1);
      check_val({tag, "_tx"}, int'(tx_of(sel)), 1);
   endtask

   initial begin
      int idle;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check_idle(1'b0, "rst_a");
      check_idle(1'b1, "rst_b");
      #1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Defaults: 0x41 on the first edge after reset, 434-cycle bits
      start(1'b0, 8'h41);
      watch(1'b0, "a41", 8'h41, 434, -1, 1'b0, 8'h00);
      check_idle(1'b0, "a41_done");

      // DIV = 10, alternating pattern
      start(1'b1, 8'h55);
      watch(1'b1, "b55", 8'h55, 10, -1, 1'b0, 8'h00);
      check_idle(1'b1, "b55_done");

      // A request during the frame is dropped; no second frame follows
      start(1'b1, 8'hA5);
      watch(1'b1, "bA5", 8'hA5, 10, 50, 1'b0, 8'h00);
      check_idle(1'b1, "bA5_done");
      idle = 0;
      for (int k = 0; k < 30; k++) begin
         if (tx_b && ready_b) idle++;
         @(posedge clk);
         #1;
      end
      check_val("bA5_no_second", idle, 30);

      // Back-to-back frames with i_valid held: 0x00 then 0xFF, no gap
      start(1'b1, 8'h00);
      watch(1'b1, "b2b0", 8'h00, 10, -1, 1'b1, 8'hFF);
      watch(1'b1, "b2b1", 8'hFF, 10, -1, 1'b0, 8'h00);
      check_idle(1'b1, "b2b_done");

      // Reset at T+37 of a 0x5A frame (bit 3 = data[2] = 0)
      start(1'b1, 8'h5A);
      drive(1'b1, 1'b0, 8'h5A);
      repeat (37) @(posedge clk);
      #1;
      check_val("pre_rst_tx", int'(tx_b), 0);
      #1;
      rst_b_n = 1'b0;
      #1;
      check_idle(1'b1, "async_rst");
      repeat (3) @(posedge clk);
      #1;
      check_idle(1'b1, "held_rst");
      rst_b_n = 1'b1;
      start(1'b1, 8'hC3);
      watch(1'b1, "bC3", 8'hC3, 10, -1, 1'b0, 8'h00);
      check_idle(1'b1, "bC3_done");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
